// File: rtl/ins_fetch_if.sv
// rtl/ins_fetch_if.sv - control, ROM and decoder-facing signals of the 8051 instruction fetch stage

interface ins_fetch_if #(
  parameter int PC_W = 16
) ();

  logic            fetch_req;
  logic            opr_req;
  logic            pc_load;
  logic [PC_W-1:0] pc_load_val;

  logic            rom_en;
  logic [PC_W-1:0] rom_addr;
  logic [7:0]      rom_data;

  logic [7:0]      instruction;
  logic [PC_W-1:0] ins_addr;
  logic            ins_valid;
  logic [7:0]      operand;
  logic            opr_valid;
  logic [PC_W-1:0] pc;
  logic            busy;

  // Control FSM + program ROM side.
  modport master (
    output fetch_req, opr_req, pc_load, pc_load_val, rom_data,
    input  rom_en, rom_addr, instruction, ins_addr, ins_valid,
           operand, opr_valid, pc, busy
  );

  // Fetch stage side.
  modport slave (
    input  fetch_req, opr_req, pc_load, pc_load_val, rom_data,
    output rom_en, rom_addr, instruction, ins_addr, ins_valid,
           operand, opr_valid, pc, busy
  );

endinterface

// File: rtl/ins_fetch.sv
// rtl/ins_fetch.sv - 8051 instruction fetch stage: PC, opcode and operand reads from synchronous ROM

module ins_fetch #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         rst_n,
  ins_fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OP_WAIT  = 2'd1,
    OPR_WAIT = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] ins_addr_q;
  logic [7:0]      instruction_q;
  logic [7:0]      operand_q;
  logic            ins_valid_q;
  logic            opr_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // pc_load wins over any read request in IDLE; requests while busy are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.pc_load) begin
          state_d = IDLE;
        end else if (bus.fetch_req) begin
          state_d = OP_WAIT;
        end else if (bus.opr_req) begin
          state_d = OPR_WAIT;
        end
      end
      OP_WAIT:  state_d = IDLE;
      OPR_WAIT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.rom_en   = 1'b0;
    bus.rom_addr = pc_q;
    bus.busy     = (state_q != IDLE);
    if (state_q == IDLE && !bus.pc_load && (bus.fetch_req || bus.opr_req)) begin
      bus.rom_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      ins_addr_q    <= RESET_PC;
      instruction_q <= 8'h00;
      operand_q     <= 8'h00;
      ins_valid_q   <= 1'b0;
      opr_valid_q   <= 1'b0;
    end else begin
      ins_valid_q <= 1'b0;
      opr_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.pc_load) begin
            pc_q <= bus.pc_load_val;
          end else if (bus.fetch_req) begin
            ins_addr_q <= pc_q;
            pc_q       <= pc_q + 1'b1;
          end else if (bus.opr_req) begin
            pc_q <= pc_q + 1'b1;
          end
        end
        // A jump during a wait retargets pc but the old-address byte still lands.
        OP_WAIT: begin
          instruction_q <= bus.rom_data;
          ins_valid_q   <= 1'b1;
          if (bus.pc_load) begin
            pc_q <= bus.pc_load_val;
          end
        end
        OPR_WAIT: begin
          operand_q   <= bus.rom_data;
          opr_valid_q <= 1'b1;
          if (bus.pc_load) begin
            pc_q <= bus.pc_load_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.ins_addr    = ins_addr_q;
  assign bus.instruction = instruction_q;
  assign bus.operand     = operand_q;
  assign bus.ins_valid   = ins_valid_q;
  assign bus.opr_valid   = opr_valid_q;

endmodule

// File: tb/tb_ins_fetch.sv
// tb/tb_ins_fetch.sv - self-checking bench for ins_fetch with a transaction-level reference model

module tb_ins_fetch;

  logic clk;
  logic rst_n;

  ins_fetch_if #(.PC_W(16)) bus ();

  ins_fetch #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rom [0:65535];

  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
  end

  int checks;
  int failures;

  // Model: one optional outstanding read, described by kind, address and the byte it returns.
  logic [15:0] m_pc;
  logic [15:0] m_ins_addr;
  logic [7:0]  m_instr;
  logic [7:0]  m_operand;
  logic        m_ins_valid;
  logic        m_opr_valid;
  bit          m_pending;
  bit          m_pending_is_op;
  logic [7:0]  m_pending_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit f, input bit o, input bit l, input logic [15:0] v, input bit r);
    bit exp_en;
    @(negedge clk);
    bus.fetch_req   = f;
    bus.opr_req     = o;
    bus.pc_load     = l;
    bus.pc_load_val = v;
    rst_n           = r;
    #1;
    exp_en = !m_pending && !l && (f || o);
    chk("rom_en", {31'd0, bus.rom_en}, {31'd0, exp_en});
    chk("busy_pre", {31'd0, bus.busy}, {31'd0, m_pending});
    if (exp_en) chk("rom_addr", {16'd0, bus.rom_addr}, {16'd0, m_pc});

    m_ins_valid = 1'b0;
    m_opr_valid = 1'b0;
    if (!r) begin
      m_pc = 16'h0000; m_ins_addr = 16'h0000; m_instr = 8'h00; m_operand = 8'h00;
      m_pending = 0;
    end else if (m_pending) begin
      if (m_pending_is_op) begin
        m_instr = m_pending_data; m_ins_valid = 1'b1;
      end else begin
        m_operand = m_pending_data; m_opr_valid = 1'b1;
      end
      m_pending = 0;
      if (l) m_pc = v;
    end else if (l) begin
      m_pc = v;
    end else if (f || o) begin
      m_pending       = 1;
      m_pending_is_op = f;
      m_pending_data  = rom[m_pc];
      if (f) m_ins_addr = m_pc;
      m_pc = m_pc + 16'd1;
    end

    @(posedge clk);
    #1;
    chk("pc", {16'd0, bus.pc}, {16'd0, m_pc});
    chk("instruction", {24'd0, bus.instruction}, {24'd0, m_instr});
    chk("ins_addr", {16'd0, bus.ins_addr}, {16'd0, m_ins_addr});
    chk("ins_valid", {31'd0, bus.ins_valid}, {31'd0, m_ins_valid});
    chk("operand", {24'd0, bus.operand}, {24'd0, m_operand});
    chk("opr_valid", {31'd0, bus.opr_valid}, {31'd0, m_opr_valid});
    chk("busy", {31'd0, bus.busy}, {31'd0, m_pending});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
    bus.fetch_req = 0; bus.opr_req = 0; bus.pc_load = 0; bus.pc_load_val = '0;
    bus.rom_data = 8'h00;
    rst_n = 0;
    m_pc = 16'h0000; m_ins_addr = 16'h0000; m_instr = 8'h00; m_operand = 8'h00;
    m_ins_valid = 0; m_opr_valid = 0; m_pending = 0; m_pending_is_op = 0; m_pending_data = 8'h00;

    // Reset
    rom[0] = 8'hE5;
    step(0, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0);
    chk("reset_pc", {16'd0, bus.pc}, 32'h0);
    chk("reset_instr", {24'd0, bus.instruction}, 32'h0);

    // Opcode fetch
    rom[0] = 8'h74;
    step(1, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    chk("fetch_instr", {24'd0, bus.instruction}, 32'h74);
    chk("fetch_pc", {16'd0, bus.pc}, 32'h1);

    // Opcode + operand, with a fetch while busy ignored
    rom[1] = 8'h74;
    rom[2] = 8'h5A;
    step(1, 0, 0, 16'h0, 1);
    step(1, 0, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    chk("opr_operand", {24'd0, bus.operand}, 32'h5A);
    chk("opr_pc", {16'd0, bus.pc}, 32'h3);

    // Jump collision and jump during OP_WAIT
    rom[16'h1234] = 8'hC3;
    step(1, 0, 1, 16'h1234, 1);
    chk("jump_pc", {16'd0, bus.pc}, 32'h1234);
    step(1, 0, 0, 16'h0, 1);
    step(0, 0, 1, 16'h0040, 1);
    chk("jump_wait_instr", {24'd0, bus.instruction}, 32'hC3);
    chk("jump_wait_pc", {16'd0, bus.pc}, 32'h0040);

    // Wrap
    rom[16'hFFFF] = 8'hA5;
    step(0, 0, 1, 16'hFFFF, 1);
    step(1, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    chk("wrap_ins_addr", {16'd0, bus.ins_addr}, 32'hFFFF);
    chk("wrap_pc", {16'd0, bus.pc}, 32'h0);

    // Reset during OP_WAIT
    rom[0] = 8'h3C;
    step(1, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 0);
    chk("midreset_valid", {31'd0, bus.ins_valid}, 32'h0);
    step(0, 0, 0, 16'h0, 1);
    step(1, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    chk("after_reset_instr", {24'd0, bus.instruction}, 32'h3C);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), 16'($urandom),
           ($urandom_range(0, 31) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ins_fetch.md
Name: ins_fetch

Overview:
- Instruction fetch stage of the 8051 CPU core. Sits directly upstream of the instruction decoder.
- Reads opcode bytes and immediate/direct operand bytes from the synchronous program ROM. Maintains the program counter (PC).
- Presents the registered opcode on `instruction` for the decoder, and the operand byte to the execute/control logic.
- Driven by the control FSM through `fetch_req`, `opr_req` and `pc_load`.

Parameters:
- PC_W, 16, program counter and ROM address width
- RESET_PC, 16'h0000, PC value after reset

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- fetch_req  input  1  request fetch of next opcode at PC
- opr_req  input  1  request fetch of next operand byte at PC
- pc_load  input  1  load PC with pc_load_val (jump/call/ret)
- pc_load_val  input  PC_W  new PC value
- rom_en  output  1  ROM read enable (combinational)
- rom_addr  output  PC_W  ROM read address (combinational, equals pc)
- rom_data  input  8  ROM read data, valid the cycle after rom_en sampled high
- instruction  output  8  opcode register, feeds decoder
- ins_addr  output  PC_W  address the current opcode was fetched from
- ins_valid  output  1  one-cycle pulse, instruction just updated
- operand  output  8  operand register
- opr_valid  output  1  one-cycle pulse, operand just updated
- pc  output  PC_W  current program counter (address of next byte)
- busy  output  1  high while a ROM read is in flight

Behaviour:
- Reset:
  - rst_n low at a rising edge forces state=IDLE, pc=RESET_PC, instruction=8'h00 (NOP), ins_addr=RESET_PC, operand=8'h00, ins_valid=0, opr_valid=0.
  - Reset mid-read discards the in-flight ROM data; no valid pulse follows.
- FSM states: IDLE, OP_WAIT, OPR_WAIT (2-bit encoding). busy = (state != IDLE).
- IDLE priority: pc_load > fetch_req > opr_req.
  - pc_load: pc <= pc_load_val. No read issued, stay IDLE.
  - fetch_req: rom_en=1, rom_addr=pc this cycle. At edge: ins_addr <= pc, pc <= pc+1, go to OP_WAIT.
  - opr_req (no fetch_req): rom_en=1, rom_addr=pc. At edge: pc <= pc+1, go to OPR_WAIT.
  - rom_en=0 in all other cases and states.
- OP_WAIT: at edge, instruction <= rom_data, ins_valid <= 1, go to IDLE.
- OPR_WAIT: at edge, operand <= rom_data, opr_valid <= 1, go to IDLE.
- Latency:
  - Request sampled in cycle N → register updated at end of cycle N+1 → valid pulse high in cycle N+2 only.
  - Back-to-back reads: a request held high is accepted again in cycle N+2 (the IDLE cycle), so one read is issued per 2 cycles.
- Requests while busy are ignored (not queued). The control FSM holds or re-asserts the request.
- pc_load in OP_WAIT/OPR_WAIT: pc <= pc_load_val at that edge. The in-flight capture still completes normally with the old-address data.
- PC arithmetic: modulo 2^PC_W. PC 16'hFFFF + 1 = 16'h0000, no flag.
- instruction and operand hold their values until the next capture of the same kind. The valid pulses deassert automatically after one cycle.
- fetch_req and opr_req asserted together in IDLE: only the opcode fetch is issued.

Test Plan:
- Reset: ROM[0]=8'hE5, hold rst_n low 2 cycles → pc=0, instruction=8'h00, ins_valid=0, busy=0, rom_en=0.
- Opcode fetch: pc=0, ROM[0]=8'h74, fetch_req pulse in cycle N → rom_en=1 and rom_addr=0 in N; busy=1 in N+1; instruction=8'h74, ins_addr=0, ins_valid=1, pc=1 in N+2.
- Opcode + operand: ROM[1]=8'h74, ROM[2]=8'h5A, fetch then opr_req once IDLE → instruction=8'h74, then operand=8'h5A with opr_valid pulse; pc=3. A fetch_req during busy is ignored.
- Jump and collisions:
  - pc_load=1, pc_load_val=16'h1234 together with fetch_req in IDLE → pc=16'h1234, no read issued.
  - Next fetch reads ROM[16'h1234]; pc_load during OP_WAIT still captures the old opcode.
- Wrap: pc_load_val=16'hFFFF, then fetch → rom_addr=16'hFFFF, ins_addr=16'hFFFF, pc=16'h0000 afterwards.
- Reset mid-operation: rst_n low during OP_WAIT → no ins_valid pulse, instruction=8'h00, pc=RESET_PC next cycle; a new fetch_req works normally.
